// File: rtl/mem_arb.sv
// mem_arb: arbitrates an instruction-fetch port and a data-memory port onto one
// memory bus. Each transaction walks IDLE -> ACC -> ACK -> IDLE. A misaligned
// address skips the memory cycle and goes straight to ACK. A stalled memory is
// cut off after TIMEOUT wait cycles.
module mem_arb #(
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    localparam logic [1:0]  GNT_NONE = 2'b00;
    localparam logic [1:0]  GNT_IF   = 2'b01;
    localparam logic [1:0]  GNT_DM   = 2'b10;
    localparam logic [7:0]  TMO_C    = 8'(TIMEOUT);
    localparam logic [31:0] POISON_C = 32'hDEADBEEF;
    localparam logic        FAIR_C   = (FAIR != 0);

    // A word access needs the two low address bits clear.
    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  grant_r, grant_nxt_s;
    logic [7:0]  wait_r, wait_nxt_s, wait_inc_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [31:0] wdata_r, wdata_nxt_s;
    logic        we_r, we_nxt_s;
    logic        last_dm_r;
    logic        pick_dm_s, take_s, misal_s, timeout_s;
    logic        rd_upd_s;
    logic [31:0] rd_val_s;
    logic        err_r, mem_en_r, mem_we_r, if_ack_r, dm_ack_r;
    logic [31:0] if_rdata_r, dm_rdata_r;

    assign wait_inc_s = wait_r + 8'd1;

    // Next-state, arbitration and read-data selection.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        wait_nxt_s  = wait_r;
        addr_nxt_s  = addr_r;
        wdata_nxt_s = wdata_r;
        we_nxt_s    = we_r;
        pick_dm_s   = 1'b0;
        take_s      = 1'b0;
        misal_s     = 1'b0;
        timeout_s   = 1'b0;
        rd_upd_s    = 1'b0;
        rd_val_s    = 32'd0;
        case (state_r)
            ST_IDLE: begin
                wait_nxt_s  = 8'd0;
                grant_nxt_s = GNT_NONE;
                if (if_req && dm_req) begin
                    // Tie: alternate when fair, otherwise data always wins.
                    if (FAIR_C) begin
                        pick_dm_s = ~last_dm_r;
                    end else begin
                        pick_dm_s = 1'b1;
                    end
                end else begin
                    pick_dm_s = dm_req;
                end
                if (if_req || dm_req) begin
                    take_s      = 1'b1;
                    grant_nxt_s = pick_dm_s ? GNT_DM : GNT_IF;
                    addr_nxt_s  = pick_dm_s ? dm_addr : if_addr;
                    wdata_nxt_s = pick_dm_s ? dm_wdata : 32'd0;
                    we_nxt_s    = pick_dm_s & dm_we;
                    misal_s     = is_misaligned(addr_nxt_s);
                    if (misal_s) begin
                        state_nxt_s = ST_ACK;
                        rd_upd_s    = ~we_nxt_s;
                        rd_val_s    = 32'd0;
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (mem_rdy) begin
                    state_nxt_s = ST_ACK;
                    rd_upd_s    = ~we_r;
                    rd_val_s    = mem_rdata;
                end else begin
                    wait_nxt_s = wait_inc_s;
                    if (wait_inc_s == TMO_C) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = ST_ACK;
                        rd_upd_s    = ~we_r;
                        rd_val_s    = POISON_C;
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GNT_NONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = GNT_NONE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched request, wait counter, registered bus/handshake outputs and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r    <= GNT_NONE;
            wait_r     <= 8'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            we_r       <= 1'b0;
            last_dm_r  <= 1'b1;
            err_r      <= 1'b0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            if_ack_r   <= 1'b0;
            dm_ack_r   <= 1'b0;
            if_rdata_r <= 32'd0;
            dm_rdata_r <= 32'd0;
        end else begin
            grant_r  <= grant_nxt_s;
            wait_r   <= wait_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            we_r     <= we_nxt_s;
            mem_en_r <= (state_nxt_s == ST_ACC);
            mem_we_r <= (state_nxt_s == ST_ACC) & we_nxt_s;
            if_ack_r <= (state_nxt_s == ST_ACK) && (grant_nxt_s == GNT_IF);
            dm_ack_r <= (state_nxt_s == ST_ACK) && (grant_nxt_s == GNT_DM);
            if (take_s) begin
                last_dm_r <= pick_dm_s;
            end
            if (misal_s || timeout_s) begin
                err_r <= 1'b1;
            end
            if (rd_upd_s) begin
                if (grant_nxt_s == GNT_IF) begin
                    if_rdata_r <= rd_val_s;
                end else begin
                    dm_rdata_r <= rd_val_s;
                end
            end
        end
    end

    assign grant     = grant_r;
    assign err       = err_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed vector table, hand sequences for arbitration order
// and reset during an access, then random traffic against a transaction model.
module tb_mem_arb;
    localparam int T_C = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_rdy = 1'b0;
    logic [31:0] if_addr = 32'd0, dm_addr = 32'd0, dm_wdata = 32'd0, mem_rdata = 32'd0;
    logic        if_ack, dm_ack, mem_en, mem_we, err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [1:0]  grant;
    logic        f0_if_ack, f0_dm_ack, f0_mem_en, f0_mem_we, f0_err;
    logic [31:0] f0_if_rdata, f0_dm_rdata, f0_mem_addr, f0_mem_wdata;
    logic [1:0]  f0_grant;

    always #5 clk = ~clk;

    mem_arb #(.FAIR(1), .TIMEOUT(T_C)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .grant(grant), .err(err));

    mem_arb #(.FAIR(0), .TIMEOUT(T_C)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(f0_if_ack),
        .if_rdata(f0_if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(f0_dm_ack), .dm_rdata(f0_dm_rdata), .mem_en(f0_mem_en),
        .mem_we(f0_mem_we), .mem_addr(f0_mem_addr), .mem_wdata(f0_mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .grant(f0_grant), .err(f0_err));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // memory environment: 16 words, responds after w_cur wait cycles
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    int          w_cur = 0;
    int          acc_cnt = 0;
    bit          auto_w = 1'b0;

    typedef struct {
        bit ir; bit dr; bit we;
        logic [31:0] ia; logic [31:0] da; logic [31:0] wd; logic [31:0] mv;
        int w;
        logic [1:0] eg; int lat; logic [31:0] erd; bit eerr; int een; int ewe;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mem_drive();
        if (mem_en) begin
            mem_rdata = env_mem[mem_addr[5:2]];
            if (acc_cnt == w_cur) begin
                mem_rdy = 1'b1;
                if (mem_we) env_mem[mem_addr[5:2]] = mem_wdata;
            end else begin
                mem_rdy = 1'b0;
            end
            acc_cnt++;
        end else begin
            mem_rdy = 1'b0;
            acc_cnt = 0;
            if (auto_w) w_cur = ($urandom_range(0, 5) == 0) ? 9 : int'($urandom_range(0, 3));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0;
        tick(); tick();
        rst = 1'b1;
    endtask

    // random-test model state
    bit          busy, t_dm, t_we, t_mis, t_to, last_dm, m_err, e_ack, e_en;
    logic [31:0] t_addr, t_wd, m_ird, m_drd, r;
    int          ack_due;

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4
                  + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    endtask

    task automatic new_dm();
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_wdata = $urandom;
        dm_addr  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4
                   + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    endtask

    logic [1:0]  fexp [4];
    logic [31:0] own_addr, own_rd, oth_rd;
    logic [1:0]  g, prev_g;
    bit          got, ack_seen, one_ack, e_err;
    int          lat, en_n, we_n, n;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h3C010001, 0, 2'b01, 2, 32'h3C010001, 1'b0, 1, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 32'hA5A50F0F, 2, 2'b10, 4, 32'hA5A50F0F, 1'b0, 3, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h12345678, 32'h0, 3, 2'b10, 5, 32'h0, 1'b0, 4, 4};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h22, 32'h0, 32'h77777777, 0, 2'b10, 1, 32'h0, 1'b1, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 32'h0, 32'h11112222, 20, 2'b10, 9, 32'hDEADBEEF, 1'b1, 8, 0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h18, 32'h0, 32'h0BADF00D, 0, 2'b01, 2, 32'h0BADF00D, 1'b0, 1, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h55555555, 0, 2'b01, 1, 32'h0, 1'b1, 0, 0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h3C, 32'h0, 32'hCAFEF00D, 7, 2'b10, 9, 32'hCAFEF00D, 1'b0, 8, 0};
        for (int i = 0; i < 16; i++) env_mem[i] = 32'd0;

        // reset state
        do_reset();
        chk("rst grant", grant, 2'b00);
        chk("rst if_ack", if_ack, 1'b0);
        chk("rst dm_ack", dm_ack, 1'b0);
        chk("rst mem_en", mem_en, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst dm_rdata", dm_rdata, 32'd0);
        chk("rst err", err, 1'b0);

        // directed vector table, one transaction per row from a fresh reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            auto_w = 1'b0;
            w_cur  = tbl[i].w;
            own_addr = (tbl[i].eg == 2'b01) ? tbl[i].ia : tbl[i].da;
            env_mem[own_addr[5:2]] = tbl[i].mv;
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            dm_req = tbl[i].dr; dm_addr = tbl[i].da; dm_we = tbl[i].we; dm_wdata = tbl[i].wd;
            got = 1'b0; lat = 0; en_n = 0; we_n = 0; g = 2'b00; one_ack = 1'b0;
            own_rd = 32'd0; oth_rd = 32'd0; e_err = 1'b0;
            for (int k = 1; k <= 20 && !got; k++) begin
                tick();
                if (mem_en) en_n++;
                if (mem_en && mem_we) we_n++;
                if (if_ack || dm_ack) begin
                    got = 1'b1; lat = k; g = grant; e_err = err;
                    one_ack = (grant == 2'b01) ? (if_ack && !dm_ack) : (dm_ack && !if_ack);
                    own_rd = (grant == 2'b01) ? if_rdata : dm_rdata;
                    oth_rd = (grant == 2'b01) ? dm_rdata : if_rdata;
                    if_req = 1'b0; dm_req = 1'b0;
                end
            end
            chk($sformatf("row%0d ack latency", i), lat, tbl[i].lat);
            chk($sformatf("row%0d grant", i), g, tbl[i].eg);
            chk($sformatf("row%0d ack port", i), one_ack, 1'b1);
            chk($sformatf("row%0d rdata", i), own_rd, tbl[i].erd);
            chk($sformatf("row%0d other rdata", i), oth_rd, 32'd0);
            chk($sformatf("row%0d err", i), e_err, tbl[i].eerr);
            chk($sformatf("row%0d mem_en cycles", i), en_n, tbl[i].een);
            chk($sformatf("row%0d mem_we cycles", i), we_n, tbl[i].ewe);
            if (tbl[i].we) chk($sformatf("row%0d stored word", i), env_mem[own_addr[5:2]], tbl[i].wd);
            tick();
            chk($sformatf("row%0d ack pulse", i), {30'd0, if_ack, dm_ack}, 32'd0);
            chk($sformatf("row%0d idle grant", i), grant, 2'b00);
            chk($sformatf("row%0d err sticky", i), err, tbl[i].eerr);
        end

        // both requests held: FAIR=1 alternates from IF, FAIR=0 always DM
        fexp[0] = 2'b01; fexp[1] = 2'b10; fexp[2] = 2'b01; fexp[3] = 2'b10;
        do_reset();
        auto_w = 1'b0; w_cur = 0;
        if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_addr = 32'h24; dm_we = 1'b0;
        n = 0; prev_g = 2'b00;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (grant != 2'b00 && prev_g == 2'b00) begin
                chk($sformatf("fair grant %0d", n), grant, fexp[n]);
                chk($sformatf("fixed grant %0d", n), f0_grant, 2'b10);
                n++;
            end
            prev_g = grant;
        end
        chk("tie grants seen", n, 4);
        if_req = 1'b0; dm_req = 1'b0;

        // reset in the middle of an access
        do_reset();
        auto_w = 1'b0; w_cur = 6;
        dm_req = 1'b1; dm_addr = 32'h08; dm_we = 1'b0;
        tick(); tick();
        chk("pre-reset mem_en", mem_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async mem_en drop", mem_en, 1'b0);
        chk("async grant drop", grant, 2'b00);
        dm_req = 1'b0;
        #2 rst = 1'b1;
        ack_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            ack_seen = ack_seen | if_ack | dm_ack;
        end
        chk("no ack after reset", ack_seen, 1'b0);
        w_cur = 0; env_mem[4] = 32'h3C010001;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("post-reset mem_en", mem_en, 1'b1);
        chk("post-reset grant", grant, 2'b01);
        tick();
        chk("post-reset if_ack", if_ack, 1'b1);
        chk("post-reset if_rdata", if_rdata, 32'h3C010001);
        chk("post-reset err", err, 1'b0);
        if_req = 1'b0;

        // random traffic against a transaction-level model
        do_reset();
        auto_w = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            env_mem[i] = ref_mem[i];
        end
        busy = 1'b0; last_dm = 1'b1; m_err = 1'b0; m_ird = 32'd0; m_drd = 32'd0; ack_due = -1;
        t_dm = 1'b0; t_we = 1'b0; t_mis = 1'b0; t_to = 1'b0; t_addr = 32'd0; t_wd = 32'd0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (busy) begin
                if (cyc == ack_due + 1) busy = 1'b0;
            end else if (if_req || dm_req) begin
                t_dm    = (if_req && dm_req) ? !last_dm : dm_req;
                last_dm = t_dm;
                busy    = 1'b1;
                t_addr  = t_dm ? dm_addr : if_addr;
                t_we    = t_dm ? dm_we : 1'b0;
                t_wd    = dm_wdata;
                t_mis   = (t_addr[1:0] != 2'b00);
                t_to    = !t_mis && (w_cur >= T_C);
                ack_due = t_mis ? cyc : ((w_cur < T_C) ? cyc + w_cur + 1 : cyc + T_C);
            end
            e_ack = busy && (cyc == ack_due);
            if (e_ack) begin
                if (!t_we) begin
                    r = t_mis ? 32'd0 : (t_to ? 32'hDEADBEEF : ref_mem[t_addr[5:2]]);
                    if (t_dm) m_drd = r; else m_ird = r;
                end else if (!t_mis && !t_to) begin
                    ref_mem[t_addr[5:2]] = t_wd;
                end
                if (t_mis || t_to) m_err = 1'b1;
            end
            chk("rnd grant", grant, busy ? (t_dm ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd if_ack", if_ack, e_ack && !t_dm);
            chk("rnd dm_ack", dm_ack, e_ack && t_dm);
            chk("rnd if_rdata", if_rdata, m_ird);
            chk("rnd dm_rdata", dm_rdata, m_drd);
            chk("rnd err", err, m_err);
            e_en = busy && !t_mis && (cyc < ack_due);
            chk("rnd mem_en", mem_en, e_en);
            chk("rnd no IF store", mem_we && (grant == 2'b01), 1'b0);
            if (e_en) begin
                chk("rnd mem_addr", mem_addr, t_addr);
                chk("rnd mem_we", mem_we, t_we);
                if (t_we) chk("rnd mem_wdata", mem_wdata, t_wd);
            end
            // stimulus for the next cycle
            if (e_ack) begin
                if (t_dm) begin
                    if ($urandom_range(0, 1) == 1) new_dm(); else dm_req = 1'b0;
                end else begin
                    if ($urandom_range(0, 1) == 1) new_if(); else if_req = 1'b0;
                end
            end else if (busy && $urandom_range(0, 3) == 0) begin
                if (t_dm) begin
                    dm_addr = $urandom; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
                end else begin
                    if_addr = $urandom;
                end
            end
            if (!if_req && $urandom_range(0, 3) == 0) new_if();
            if (!dm_req && $urandom_range(0, 3) == 0) new_dm();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
